// File: rtl/sensor_image_frame_packer.sv
// Packs the cropped pixel stream into PACK_NUM-pixel words for the frame-buffer
// write FIFO, checks per-frame geometry and FIFO health, and reports status.
module sensor_image_frame_packer #(
    parameter int PIXEL_DATA_WIDTH = 16,
    parameter int PACK_NUM         = 4,
    parameter int IMAGE_HSIZE      = 1280,
    parameter int IMAGE_VSIZE      = 960
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 image_in_vsync,
    input  logic                                 image_in_href,
    input  logic                                 image_in_de,
    input  logic [PIXEL_DATA_WIDTH-1:0]          image_in_data,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr_en,
    output logic [PIXEL_DATA_WIDTH*PACK_NUM-1:0] fifo_wr_data,
    output logic                                 frame_start,
    output logic                                 frame_done,
    output logic                                 frame_ok,
    output logic                                 err_overflow,
    output logic                                 err_hsize,
    output logic                                 err_vsize,
    output logic [15:0]                          frame_cnt
);

    localparam int              IDX_W     = $clog2(PACK_NUM);
    localparam int              WORD_W    = PIXEL_DATA_WIDTH * PACK_NUM;
    localparam logic [15:0]     HSIZE_CNT = 16'(IMAGE_HSIZE);
    localparam logic [11:0]     VSIZE_CNT = 12'(IMAGE_VSIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } state_t;

    // Registered copies of the inputs
    logic                        vsync_reg;
    logic                        href_reg;
    logic                        de_reg;
    logic [PIXEL_DATA_WIDTH-1:0] data_reg;
    logic                        fifo_full_reg;

    // Control state
    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [WORD_W-1:0]           pack_buf_reg, pack_buf_next;
    logic [15:0]                 pix_cnt_reg, pix_cnt_next;
    logic [11:0]                 line_cnt_reg, line_cnt_next;

    // Output registers
    logic                        wr_en_reg, wr_en_next;
    logic [WORD_W-1:0]           wr_data_reg, wr_data_next;
    logic                        frame_start_reg, frame_start_next;
    logic                        frame_done_reg, frame_done_next;
    logic                        frame_ok_reg, frame_ok_next;
    logic                        err_overflow_reg, err_overflow_next;
    logic                        err_hsize_reg, err_hsize_next;
    logic                        err_vsize_reg, err_vsize_next;
    logic [15:0]                 frame_cnt_reg, frame_cnt_next;

    // Combinational helpers
    logic                        accept;
    logic                        accept_active;
    logic                        href_fall;
    logic                        vsync_rise;
    logic                        vsync_fall;
    logic [WORD_W-1:0]           merged_word;
    logic                        want_write;
    logic [15:0]                 line_pix;
    logic [11:0]                 line_after;

    // Edges compare the registered copy against the live input
    assign accept        = vsync_reg & href_reg & de_reg;
    assign accept_active = accept && (state_reg == ST_ACTIVE);
    assign href_fall     = href_reg & ~image_in_href;
    assign vsync_rise    = image_in_vsync & ~vsync_reg;
    assign vsync_fall    = vsync_reg & ~image_in_vsync;

    // Current partial word with the newly accepted pixel dropped into its slot
    generate
        for (genvar gi = 0; gi < PACK_NUM; gi++) begin : g_slot
            assign merged_word[gi*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] =
                (accept_active && (idx_reg == IDX_W'(gi))) ? data_reg
                    : pack_buf_reg[gi*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
        end
    endgenerate

    // Input pipeline: sampled even during reset so a vsync already high at
    // reset release is not mistaken for a rising edge
    always_ff @(posedge clk) begin
        vsync_reg     <= image_in_vsync;
        href_reg      <= image_in_href;
        de_reg        <= image_in_de;
        data_reg      <= image_in_data;
        fifo_full_reg <= fifo_full;
    end

    // State and output register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            pack_buf_reg     <= '0;
            pix_cnt_reg      <= '0;
            line_cnt_reg     <= '0;
            wr_en_reg        <= 1'b0;
            wr_data_reg      <= '0;
            frame_start_reg  <= 1'b0;
            frame_done_reg   <= 1'b0;
            frame_ok_reg     <= 1'b0;
            err_overflow_reg <= 1'b0;
            err_hsize_reg    <= 1'b0;
            err_vsize_reg    <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            pack_buf_reg     <= pack_buf_next;
            pix_cnt_reg      <= pix_cnt_next;
            line_cnt_reg     <= line_cnt_next;
            wr_en_reg        <= wr_en_next;
            wr_data_reg      <= wr_data_next;
            frame_start_reg  <= frame_start_next;
            frame_done_reg   <= frame_done_next;
            frame_ok_reg     <= frame_ok_next;
            err_overflow_reg <= err_overflow_next;
            err_hsize_reg    <= err_hsize_next;
            err_vsize_reg    <= err_vsize_next;
            frame_cnt_reg    <= frame_cnt_next;
        end
    end

    // Next-state logic: frame tracking, packing, geometry and overflow checks
    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        pack_buf_next     = pack_buf_reg;
        pix_cnt_next      = pix_cnt_reg;
        line_cnt_next     = line_cnt_reg;
        wr_en_next        = 1'b0;
        wr_data_next      = wr_data_reg;
        frame_start_next  = 1'b0;
        frame_done_next   = 1'b0;
        frame_ok_next     = frame_ok_reg;
        err_overflow_next = err_overflow_reg;
        err_hsize_next    = err_hsize_reg;
        err_vsize_next    = err_vsize_reg;
        frame_cnt_next    = frame_cnt_reg;
        want_write        = 1'b0;
        line_pix          = pix_cnt_reg;
        line_after        = line_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_next        = ST_ACTIVE;
                    frame_start_next  = 1'b1;
                    err_overflow_next = 1'b0;
                    err_hsize_next    = 1'b0;
                    err_vsize_next    = 1'b0;
                    pix_cnt_next      = '0;
                    line_cnt_next     = '0;
                    idx_next          = '0;
                    pack_buf_next     = '0;
                end
            end

            ST_ACTIVE, ST_DROP: begin
                // Geometry keeps being tracked in DROP so the line count stays meaningful
                if (accept && (pix_cnt_reg != 16'hFFFF)) begin
                    line_pix = pix_cnt_reg + 16'd1;
                end
                pix_cnt_next = line_pix;
                if (href_fall) begin
                    if (line_pix != HSIZE_CNT) begin
                        err_hsize_next = 1'b1;
                    end
                    pix_cnt_next = '0;
                    if (line_cnt_reg != 12'hFFF) begin
                        line_after = line_cnt_reg + 12'd1;
                    end
                    line_cnt_next = line_after;
                end

                if (state_reg == ST_ACTIVE) begin
                    if (accept) begin
                        pack_buf_next = merged_word;
                        if (idx_reg == IDX_W'(PACK_NUM - 1)) begin
                            want_write = 1'b1;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end
                    // Line ended mid-group: flush the zero-padded partial word
                    if (href_fall && (idx_next != '0)) begin
                        want_write = 1'b1;
                    end
                    if (want_write) begin
                        pack_buf_next = '0;
                        idx_next      = '0;
                        if (fifo_full_reg) begin
                            err_overflow_next = 1'b1;
                            state_next        = ST_DROP;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_data_next = merged_word;
                        end
                    end
                end

                if (vsync_fall) begin
                    if (line_after != VSIZE_CNT) begin
                        err_vsize_next = 1'b1;
                    end
                    frame_done_next = 1'b1;
                    frame_ok_next   = ~(err_overflow_next | err_hsize_next | err_vsize_next);
                    frame_cnt_next  = frame_cnt_reg + 16'd1;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fifo_wr_en   = wr_en_reg;
    assign fifo_wr_data = wr_data_reg;
    assign frame_start  = frame_start_reg;
    assign frame_done   = frame_done_reg;
    assign frame_ok     = frame_ok_reg;
    assign err_overflow = err_overflow_reg;
    assign err_hsize    = err_hsize_reg;
    assign err_vsize    = err_vsize_reg;
    assign frame_cnt    = frame_cnt_reg;

endmodule

// File: tb/tb_sensor_image_frame_packer.sv
// Directed bench for sensor_image_frame_packer (8-bit pixels, 4 per word, 8x4 frame).
module tb_sensor_image_frame_packer;

    localparam int W = 8;
    localparam int P = 4;
    localparam int H = 8;
    localparam int V = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           vs  = 1'b0;
    logic           hr  = 1'b0;
    logic           de  = 1'b0;
    logic [W-1:0]   dat = '0;
    logic           full = 1'b0;

    logic           fifo_wr_en;
    logic [W*P-1:0] fifo_wr_data;
    logic           frame_start;
    logic           frame_done;
    logic           frame_ok;
    logic           err_overflow;
    logic           err_hsize;
    logic           err_vsize;
    logic [15:0]    frame_cnt;

    sensor_image_frame_packer #(
        .PIXEL_DATA_WIDTH (W),
        .PACK_NUM         (P),
        .IMAGE_HSIZE      (H),
        .IMAGE_VSIZE      (V)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .image_in_vsync (vs),
        .image_in_href  (hr),
        .image_in_de    (de),
        .image_in_data  (dat),
        .fifo_full      (full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .frame_ok       (frame_ok),
        .err_overflow   (err_overflow),
        .err_hsize      (err_hsize),
        .err_vsize      (err_vsize),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_q[$];
    int          wr_cyc_q[$];
    int          px4_q[$];
    int          start_cnt = 0;
    int          done_cnt  = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    bit          ovf_arm   = 1'b0;

    // Collect writes and frame pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en) begin
                wr_q.push_back(fifo_wr_data);
                wr_cyc_q.push_back(cyc);
                $display("write #%0d data=0x%08h cyc=%0d", wr_q.size(), fifo_wr_data, cyc);
            end
            if (frame_start) start_cnt++;
            if (frame_done) begin
                done_cnt++;
                $display("frame_done ok=%0b ovf=%0b hsz=%0b vsz=%0b cnt=%0d",
                         frame_ok, err_overflow, err_hsize, err_vsize, frame_cnt);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic d, input logic [W-1:0] x);
        if (ovf_arm && wr_q.size() >= 2) full = 1'b1;
        vs = v; hr = h; de = d; dat = x;
        tick();
    endtask

    task automatic send_line(input int n, input int base, input bit gap);
        for (int i = 0; i < n; i++) begin
            if ((i % 4) == 3) px4_q.push_back(cyc);
            drive(1'b1, 1'b1, 1'b1, 8'(base + i));
            if (gap) drive(1'b1, 1'b1, 1'b0, 8'hEE);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        wr_q.delete();
        wr_cyc_q.delete();
        px4_q.delete();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic end_frame();
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [31:0] nom_word(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    task automatic check_nominal_words(input string tag);
        check({tag, "_nwr"}, wr_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wr_q.size()) check($sformatf("%s_w%0d", tag, k), wr_q[k], nom_word(k));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
        check({tag, "_start"}, frame_start, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_ok"}, frame_ok, 0);
        check({tag, "_ovf"}, err_overflow, 0);
        check({tag, "_hsz"}, err_hsize, 0);
        check({tag, "_vsz"}, err_vsize, 0);
        check({tag, "_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Nominal frame
        s0 = start_cnt; d0 = done_cnt;
        start_frame();
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b0);
        end_frame();
        check_nominal_words("nom");
        check("nom_first", wr_q[0], 32'h03020100);
        check("nom_last", wr_q[wr_q.size()-1], 32'h1F1E1D1C);
        check("nom_starts", start_cnt - s0, 1);
        check("nom_dones", done_cnt - d0, 1);
        check("nom_ok", frame_ok, 1);
        check("nom_cnt", frame_cnt, 1);
        check("nom_hsz", err_hsize, 0);
        check("nom_vsz", err_vsize, 0);

        // Short third line: zero-padded partial word
        start_frame();
        send_line(8, 0, 1'b0);
        send_line(8, 8, 1'b0);
        send_line(6, 16, 1'b0);
        send_line(8, 24, 1'b0);
        end_frame();
        check("short_nwr", wr_q.size(), 8);
        if (wr_q.size() == 8) begin
            check("short_w4", wr_q[4], 32'h13121110);
            check("short_w5", wr_q[5], 32'h00001514);
            check("short_w6", wr_q[6], 32'h1B1A1918);
        end
        check("short_hsz", err_hsize, 1);
        check("short_vsz", err_vsize, 0);
        check("short_ok", frame_ok, 0);
        check("short_cnt", frame_cnt, 2);

        // Gapped de: same words, latency one cycle after acceptance
        s0 = start_cnt;
        start_frame();
        check("gap_hsz_cleared", err_hsize, 0);
        check("gap_starts", start_cnt - s0, 1);
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b1);
        end_frame();
        check_nominal_words("gap");
        check("gap_npx4", px4_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wr_cyc_q.size() && k < px4_q.size())
                check($sformatf("gap_lat%0d", k), wr_cyc_q[k] - px4_q[k], 2);
        end
        check("gap_ok", frame_ok, 1);
        check("gap_cnt", frame_cnt, 3);

        // Overflow on the third write
        d0 = done_cnt;
        start_frame();
        ovf_arm = 1'b1;
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b0);
        end_frame();
        ovf_arm = 1'b0;
        full = 1'b0;
        check("ovf_nwr", wr_q.size(), 2);
        check("ovf_flag", err_overflow, 1);
        check("ovf_ok", frame_ok, 0);
        check("ovf_dones", done_cnt - d0, 1);
        check("ovf_cnt", frame_cnt, 4);

        // Recovery frame after overflow
        start_frame();
        check("rec_ovf_cleared", err_overflow, 0);
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b0);
        end_frame();
        check_nominal_words("rec");
        check("rec_ok", frame_ok, 1);
        check("rec_cnt", frame_cnt, 5);

        // Reset released with vsync already high: partial frame ignored
        rst = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        wr_q.delete();
        s0 = start_cnt; d0 = done_cnt;
        send_line(8, 0, 1'b0);
        send_line(8, 8, 1'b0);
        end_frame();
        check("mid_nwr", wr_q.size(), 0);
        check("mid_starts", start_cnt - s0, 0);
        check("mid_dones", done_cnt - d0, 0);
        check("mid_cnt", frame_cnt, 0);

        // Three-line frame: vsize error
        start_frame();
        for (int l = 0; l < 3; l++) send_line(8, l * 8, 1'b0);
        end_frame();
        check("v3_nwr", wr_q.size(), 6);
        check("v3_vsz", err_vsize, 1);
        check("v3_hsz", err_hsize, 0);
        check("v3_ok", frame_ok, 0);
        check("v3_cnt", frame_cnt, 1);

        // Reset mid-frame after three writes
        d0 = done_cnt;
        start_frame();
        send_line(8, 0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 8'(8 + i));
        check("rmid_nwr_before", wr_q.size(), 3);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h0E);
        check_all_zero("rmid");
        drive(1'b1, 1'b1, 1'b1, 8'h0F);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        end_frame();
        check("rmid_nwr_after", wr_q.size(), 3);
        check("rmid_dones", done_cnt - d0, 0);

        start_frame();
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b0);
        end_frame();
        check_nominal_words("post");
        check("post_ok", frame_ok, 1);
        check("post_cnt", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
